bus_copy_dma: RTL and testbench
===============================

// Module: bus_copy_dma
// PURPOSE
//  Word-copy engine acting as initiator (bus_if.master) on the SoC req/gnt/rvalid bus.
//  - Copies len_i 32-bit words from src_addr_i to dst_addr_i using read-then-write transactions.
//  - Talks to any bus_if responder, e.g. the SRAM bank wrapper; used for boot image relocation and buffer moves.
//  - Keeps exactly one transaction outstanding.
// PARAMETERS
//  LEN_WIDTH   16   width of word-count operands/counters
//  DATA_WIDTH  32   bus data width; be is DATA_WIDTH/8 bits
// PORTS
//  clk_i          in   1          clock
//  rst_ni         in   1          reset, asynchronous, active-low
//  bus            -    bus_if     master modport: drives req,we,be,addr,wdata; samples gnt,rvalid,rdata,err
//  start_i        in   1          start request, sampled only when idle
//  src_addr_i     in   32         source byte address, bits[1:0] ignored
//  dst_addr_i     in   32         destination byte address, bits[1:0] ignored
//  len_i          in   LEN_WIDTH  number of words to copy
//  busy_o         out  1          transfer in progress
//  done_o         out  1          one-cycle pulse at end of transfer, including aborts
//  err_o          out  1          sticky: last transfer aborted on bus err
//  words_done_o   out  LEN_WIDTH  words fully written in current/last transfer
// BEHAVIOUR
//  Reset: req=0, we=0, be=0, addr=0, wdata=0, busy_o=0, done_o=0, err_o=0, words_done_o=0, state IDLE.
//  Reset mid-transfer aborts immediately: req drops asynchronously and no done_o pulse is produced.
//  FSM states and transitions:
//   IDLE: on start_i, latch src/dst (bits[1:0] forced 0) and len, clear err_o and words_done_o.
//         If len_i==0 go to DONE; else go to RD_REQ. start_i is ignored in all other states.
//   RD_REQ: req=1, we=0, be='1, addr=src+4*i. Hold stable until gnt; on gnt go to RD_WAIT.
//   RD_WAIT: req=0. On rvalid: if err, go to DONE with err_o set; else capture rdata into buffer, go to WR_REQ.
//   WR_REQ: req=1, we=1, be='1, addr=dst+4*i, wdata=buffer. Hold stable until gnt; on gnt go to WR_WAIT.
//   WR_WAIT: req=0. On rvalid with err: go to DONE, err_o set, no increment.
//            Otherwise i++ and words_done_o++; go to DONE if i==len, else RD_REQ.
//   DONE: done_o=1 for one cycle, busy_o=0 next cycle; go to IDLE.
//  busy_o=1 in every state except IDLE.
//  Handshake rules:
//   - addr/we/be/wdata are registered and stable while req=1 and gnt=0.
//   - gnt and rvalid may arrive the same cycle as req (grant) or later; any latency is tolerated.
//   - rvalid outside RD_WAIT/WR_WAIT is ignored (flag with an assertion).
//   - rdata is sampled only on rvalid in RD_WAIT.
//  Timing against a zero-wait responder (gnt=req, rvalid one cycle later):
//   - 4 cycles per word.
//   - With start sampled at edge 0, done_o is high in cycle 4N+1.
//  Arithmetic:
//   - Addresses are computed as base + (i<<2), modulo 2^32; wrap past 0xFFFF_FFFC is legal and silent.
//   - i is LEN_WIDTH wide; len = 2^LEN_WIDTH-1 is the maximum.
//  Simultaneous events:
//   - start_i during DONE is ignored.
//   - gnt with err-free rvalid in the same cycle is impossible in WAIT states, since req=0 there.
// STRUCTURE
//  - dma_pkg: typedef enum {IDLE,RD_REQ,RD_WAIT,WR_REQ,WR_WAIT,DONE} dma_state_e; constant WORD_BYTES=4.
//  - Single module. No sub-module is needed; the FSM, address counter and data buffer all live here.
// TESTING
//  1. src=0x100, dst=0x200, len=4, zero-wait SRAM model -> dst words equal src words; done_o in cycle 17;
//     words_done_o=4; err_o=0.
//  2. len=0 -> no req ever asserted; done_o pulses in cycle 1; busy_o high for cycle 1 only.
//  3. Responder stalls gnt 3 cycles on each req -> addr/we/wdata stable while req && !gnt; data copied correctly.
//  4. err asserted with rvalid on read of word 2 (len=5) -> words_done_o=2; err_o=1; done_o pulse;
//     next start clears err_o.
//  5. src=0xFFFF_FFF8, len=3 -> read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
//  6. rst_ni low during WR_REQ of word 1 -> req=0 immediately; all outputs at reset values; no done_o pulse.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and address helpers for the bus word-copy engine.
package dma_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } dma_state_e;

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~ADDR_WIDTH'(WORD_BYTES - 1);
    endfunction

    // Wraps modulo 2^ADDR_WIDTH by construction.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [ADDR_WIDTH-1:0] idx);
        return base + idx * ADDR_WIDTH'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/bus_if.sv
// SoC req/gnt/rvalid bus: one request per grant, one rvalid response per granted request.
interface bus_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                    req;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/bus_copy_dma.sv
// Word-copy engine: reads len words from src and writes them to dst, one bus
// transaction outstanding at a time; aborts on the first bus error.
module bus_copy_dma
    import dma_pkg::*;
#(
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    bus_if.master                 bus,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [LEN_WIDTH-1:0]  words_done_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    dma_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  err_q, err_d;

    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  busy_q, done_q;

    // cnt is both the word index and the words-written count: a word only
    // counts once its write response arrives error-free.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        err_d   = err_q;
        cnt_inc = cnt_q + LEN_WIDTH'(1);

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d   = word_align(src_addr_i);
                    dst_d   = word_align(dst_addr_i);
                    len_d   = len_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = (len_i == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                if (bus.gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.rvalid) begin
                    if (bus.err) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        buf_d   = bus.rdata;
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (bus.gnt) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (bus.rvalid) begin
                    if (bus.err) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == len_q) ? DONE : RD_REQ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they are glitch-free
    // and held stable for the whole request phase.
    always_comb begin
        req_d   = (state_d == RD_REQ) || (state_d == WR_REQ);
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_d == RD_REQ) begin
            we_d   = 1'b0;
            be_d   = '1;
            addr_d = word_addr(src_d, ADDR_WIDTH'(cnt_d));
        end else if (state_d == WR_REQ) begin
            we_d    = 1'b1;
            be_d    = '1;
            addr_d  = word_addr(dst_d, ADDR_WIDTH'(cnt_d));
            wdata_d = buf_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.be    = be_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign words_done_o = cnt_q;

    rvalid_only_in_wait_a : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        bus.rvalid |-> (state_q inside {RD_WAIT, WR_WAIT}));

endmodule

// File: tb/tb_bus_copy_dma.sv
// Directed-random bench for bus_copy_dma against a memory responder and a
// word-list reference of the expected copy.
module tb_bus_copy_dma;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o, err_o;
    logic [15:0] words_done_o;

    always #5 clk_i = ~clk_i;

    bus_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    bus_copy_dma #(.LEN_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .bus          (bus),
        .start_i      (start_i),
        .src_addr_i   (src_addr_i),
        .dst_addr_i   (dst_addr_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .words_done_o (words_done_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] mem [bit [31:0]];
    logic [31:0] rd_log [$];
    int          stall_cfg  = 0;
    int          err_rd_idx = -1;
    int          stall_cnt;
    logic        rvalid_r, err_r;
    logic [31:0] rdata_r;

    assign bus.gnt    = bus.req && (stall_cnt >= stall_cfg);
    assign bus.rvalid = rvalid_r;
    assign bus.err    = err_r;
    assign bus.rdata  = rdata_r;

    task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
        mem[a] = d;
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_r  <= 1'b0;
            err_r     <= 1'b0;
            rdata_r   <= '0;
            stall_cnt <= 0;
        end else begin
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            if (bus.req && bus.gnt) begin
                stall_cnt <= 0;
                rvalid_r  <= 1'b1;
                if (bus.we) begin
                    mem_write(bus.addr, bus.wdata);
                end else begin
                    rdata_r <= mem_read(bus.addr);
                    if (rd_log.size() == err_rd_idx) err_r <= 1'b1;
                    rd_log.push_back(bus.addr);
                end
            end else if (bus.req) begin
                stall_cnt <= stall_cnt + 1;
            end
        end
    end

    // ---------------- negedge monitor ----------------
    int          done_pulses = 0;
    bit          req_seen    = 1'b0;
    bit          check_hold  = 1'b0;
    logic        hold_valid  = 1'b0;
    logic        hold_we;
    logic [31:0] hold_addr, hold_wdata;

    always @(negedge clk_i) begin
        if (done_o) done_pulses++;
        if (bus.req) req_seen = 1'b1;
        if (check_hold && hold_valid && bus.req) begin
            check("hold_addr", bus.addr, hold_addr);
            check("hold_we", 32'(bus.we), 32'(hold_we));
            check("hold_wdata", bus.wdata, hold_wdata);
        end
        hold_valid = bus.req && !bus.gnt;
        hold_addr  = bus.addr;
        hold_we    = bus.we;
        hold_wdata = bus.wdata;
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_words [$];

    task automatic fill_src(input logic [31:0] src, input int n);
        logic [31:0] base;
        logic [31:0] w;
        base = src & ~32'h3;
        exp_words.delete();
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            mem_write(base + 32'(4 * k), w);
            exp_words.push_back(w);
        end
    endtask

    task automatic check_copy(input string tag, input logic [31:0] dst, input int n);
        logic [31:0] base;
        base = dst & ~32'h3;
        for (int k = 0; k < n; k++)
            check(tag, mem_read(base + 32'(4 * k)), exp_words[k]);
    endtask

    // Start at a negedge; the following posedge is edge 0, so cycle c is the
    // interval after edge c-1.
    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                            output int done_cycle, output int busy_cycles, output logic err_c1);
        @(negedge clk_i);
        src_addr_i = src;
        dst_addr_i = dst;
        len_i      = 16'(len);
        start_i    = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        done_cycle  = -1;
        busy_cycles = 0;
        err_c1      = 1'bx;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk_i);
            if (c == 1) err_c1 = err_o;
            if (busy_o) busy_cycles++;
            if (done_o) begin
                done_cycle = c;
                break;
            end
        end
        check("done_within_budget", 32'(done_cycle != -1), 32'd1);
        @(negedge clk_i);
        check("done_one_cycle", 32'(done_o), 32'd0);
        check("busy_low_after_done", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dc, bc, pulses0, n;
        logic        e1;
        logic [31:0] src, dst, sentinel;

        // Reset values
        #1;
        check("rst_req", 32'(bus.req), 32'd0);
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_be", 32'(bus.be), 32'd0);
        check("rst_addr", bus.addr, 32'd0);
        check("rst_wdata", bus.wdata, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_words", 32'(words_done_o), 32'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;

        // 1: basic 4-word copy, zero-wait
        rd_log.delete();
        fill_src(32'h100, 4);
        pulses0 = done_pulses;
        run_xfer(32'h100, 32'h200, 4, dc, bc, e1);
        check("t1_done_cycle", 32'(dc), 32'd17);
        check("t1_busy_cycles", 32'(bc), 32'd17);
        check("t1_words", 32'(words_done_o), 32'd4);
        check("t1_err", 32'(err_o), 32'd0);
        check("t1_pulses", 32'(done_pulses - pulses0), 32'd1);
        check_copy("t1_data", 32'h200, 4);
        for (int k = 0; k < 4; k++)
            check("t1_rd_addr", rd_log[k], 32'h100 + 32'(4 * k));

        // 2: zero-length transfer
        req_seen = 1'b0;
        pulses0  = done_pulses;
        run_xfer($urandom, $urandom, 0, dc, bc, e1);
        check("t2_done_cycle", 32'(dc), 32'd1);
        check("t2_busy_cycles", 32'(bc), 32'd1);
        check("t2_no_req", 32'(req_seen), 32'd0);
        check("t2_words", 32'(words_done_o), 32'd0);
        check("t2_pulses", 32'(done_pulses - pulses0), 32'd1);

        // 3: responder stalls every grant by 3 cycles; unaligned low bits ignored
        stall_cfg  = 3;
        check_hold = 1'b1;
        n   = $urandom_range(3, 6);
        src = 32'h0001_0000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
        dst = 32'h0002_0000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
        fill_src(src, n);
        run_xfer(src, dst, n, dc, bc, e1);
        check("t3_done_cycle", 32'(dc), 32'(10 * n + 1));
        check("t3_words", 32'(words_done_o), 32'(n));
        check("t3_err", 32'(err_o), 32'd0);
        check_copy("t3_data", dst, n);
        check_hold = 1'b0;
        stall_cfg  = 0;

        // 4: read error on word 2 of 5
        rd_log.delete();
        err_rd_idx = 2;
        src = 32'h0004_0000 + ($urandom_range(0, 255) << 2);
        dst = 32'h0005_0000 + ($urandom_range(0, 255) << 2);
        fill_src(src, 5);
        sentinel = $urandom;
        mem_write(dst + 32'd8, sentinel);
        pulses0 = done_pulses;
        run_xfer(src, dst, 5, dc, bc, e1);
        check("t4_done_cycle", 32'(dc), 32'd11);
        check("t4_words", 32'(words_done_o), 32'd2);
        check("t4_err", 32'(err_o), 32'd1);
        check("t4_pulses", 32'(done_pulses - pulses0), 32'd1);
        check_copy("t4_data", dst, 2);
        check("t4_no_write_word2", mem_read(dst + 32'd8), sentinel);
        err_rd_idx = -1;
        rd_log.delete();
        fill_src(32'h0006_0000, 1);
        run_xfer(32'h0006_0000, 32'h0007_0000, 1, dc, bc, e1);
        check("t4_err_cleared_c1", 32'(e1), 32'd0);
        check("t4_err_after", 32'(err_o), 32'd0);
        check("t4_retry_done_cycle", 32'(dc), 32'd5);
        check_copy("t4_retry_data", 32'h0007_0000, 1);

        // 5: source address wraps past the top of the address space
        rd_log.delete();
        fill_src(32'hFFFF_FFF8, 3);
        run_xfer(32'hFFFF_FFF8, 32'h0000_3000, 3, dc, bc, e1);
        check("t5_rd_addr0", rd_log[0], 32'hFFFF_FFF8);
        check("t5_rd_addr1", rd_log[1], 32'hFFFF_FFFC);
        check("t5_rd_addr2", rd_log[2], 32'h0000_0000);
        check("t5_done_cycle", 32'(dc), 32'd13);
        check_copy("t5_data", 32'h0000_3000, 3);

        // 6: reset asserted during the write request of word 1
        fill_src(32'h0008_0000, 3);
        @(negedge clk_i);
        src_addr_i = 32'h0008_0000;
        dst_addr_i = 32'h0009_0000;
        len_i      = 16'd3;
        start_i    = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (7) @(negedge clk_i);
        check("t6_in_wr_req", 32'({bus.req, bus.we}), 32'h3);
        check("t6_words_before", 32'(words_done_o), 32'd1);
        pulses0 = done_pulses;
        rst_ni  = 1'b0;
        #1;
        check("t6_req", 32'(bus.req), 32'd0);
        check("t6_we", 32'(bus.we), 32'd0);
        check("t6_be", 32'(bus.be), 32'd0);
        check("t6_addr", bus.addr, 32'd0);
        check("t6_wdata", bus.wdata, 32'd0);
        check("t6_busy", 32'(busy_o), 32'd0);
        check("t6_done", 32'(done_o), 32'd0);
        check("t6_err", 32'(err_o), 32'd0);
        check("t6_words", 32'(words_done_o), 32'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        check("t6_no_done_pulse", 32'(done_pulses - pulses0), 32'd0);
        check("t6_idle_after", 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
